// File: rtl/mem_port_arbiter.sv
// Single-port access controller in front of the 256x16 mem block: arbitrates fetch vs
// load/store with load/store priority and a starvation bound that guarantees fetch progress.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_valid,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t             state_r, state_s;
  logic               ls_ready_s, if_ready_s;
  logic               owner_ls_r;
  logic [CNT_W-1:0]   starve_cnt_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_din_r, if_rdata_r, ls_rdata_r;
  logic               mem_we_r, if_rvalid_r, ls_rvalid_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant decision and next state; a waiting fetch overrides load/store once the bound is hit
  always_comb begin
    ls_ready_s = 1'b0;
    if_ready_s = 1'b0;
    state_s    = state_r;
    if (state_r == IDLE) begin
      ls_ready_s = ls_valid && !(if_valid && (starve_cnt_r == STARVE_LIM));
      if_ready_s = if_valid && !ls_ready_s;
    end else begin
      ls_ready_s = 1'b0;
      if_ready_s = 1'b0;
    end
    case (state_r)
      IDLE:    state_s = (ls_ready_s || if_ready_s) ? ACCESS : IDLE;
      ACCESS:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory drive, response capture and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r   <= '0;
      mem_din_r    <= '0;
      mem_we_r     <= 1'b0;
      owner_ls_r   <= 1'b0;
      starve_cnt_r <= '0;
      if_rvalid_r  <= 1'b0;
      ls_rvalid_r  <= 1'b0;
      if_rdata_r   <= '0;
      ls_rdata_r   <= '0;
    end else begin
      if_rvalid_r <= 1'b0;
      ls_rvalid_r <= 1'b0;
      if (ls_ready_s) begin
        mem_addr_r   <= ls_addr;
        mem_din_r    <= ls_wdata;
        mem_we_r     <= ls_we;
        owner_ls_r   <= 1'b1;
        // if_valid here implies the counter is below the limit, so no saturation is needed
        starve_cnt_r <= if_valid ? (starve_cnt_r + CNT_W'(1)) : '0;
      end else if (if_ready_s) begin
        mem_addr_r   <= if_addr;
        mem_we_r     <= 1'b0;
        owner_ls_r   <= 1'b0;
        starve_cnt_r <= '0;
      end else if (state_r == ACCESS) begin
        mem_we_r <= 1'b0;
        if (owner_ls_r) begin
          ls_rvalid_r <= 1'b1;
          if (!mem_we_r) begin
            ls_rdata_r <= mem_dout;
          end
        end else begin
          if_rvalid_r <= 1'b1;
          if_rdata_r  <= mem_dout;
        end
      end
    end
  end

  assign ls_ready  = ls_ready_s;
  assign if_ready  = if_ready_s;
  assign mem_addr  = mem_addr_r;
  assign mem_din   = mem_din_r;
  assign mem_we    = mem_we_r;
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign ls_rvalid = ls_rvalid_r;
  assign ls_rdata  = ls_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 256x16 memory
// (synchronous write, combinational read) attached to the mem_* port.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [7:0]  if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        ls_valid;
  logic        ls_we;
  logic [7:0]  ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_ready;
  logic        ls_rvalid;
  logic [15:0] ls_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;

  logic [15:0] mem_arr [0:255];
  int          n_cmp;
  int          n_err;
  logic [9:0]  gvec;
  int          gcount;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_din;
  end
  assign mem_dout = mem_arr[mem_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    if_valid = 1'b0; if_addr = 8'h00;
    ls_valid = 1'b0; ls_we = 1'b0; ls_addr = 8'h00; ls_wdata = 16'h0000;
    tick(); tick();
    check_val("rst_outs", 32'({if_ready, if_rvalid, if_rdata, ls_ready, ls_rvalid, ls_rdata,
                               mem_addr, mem_din, mem_we}), 32'h0);
    rst_n = 1'b1;

    // first grant in the first idle cycle after release
    if_valid = 1'b1; if_addr = 8'h00;
    #1;
    check_val("rst_if_ready", 32'(if_ready), 32'h1);
    check_val("rst_ls_ready", 32'(ls_ready), 32'h0);
    tick(); if_valid = 1'b0; #1;
    check_val("access_if_ready", 32'(if_ready), 32'h0);
    tick();
    check_val("first_if_rvalid", 32'(if_rvalid), 32'h1);
    tick();

    // store 0xFFFF to 0x07
    ls_valid = 1'b1; ls_we = 1'b1; ls_addr = 8'h07; ls_wdata = 16'hFFFF; #1;
    check_val("st_ls_ready", 32'(ls_ready), 32'h1);
    tick(); ls_valid = 1'b0; #1;
    check_val("st_we_n1", 32'(mem_we), 32'h1);
    check_val("st_addr", 32'(mem_addr), 32'h07);
    check_val("st_din", 32'(mem_din), 32'hFFFF);
    check_val("st_rvalid_n1", 32'(ls_rvalid), 32'h0);
    tick();
    check_val("st_we_n2", 32'(mem_we), 32'h0);
    check_val("st_rvalid_n2", 32'(ls_rvalid), 32'h1);
    tick();
    check_val("st_rvalid_n3", 32'(ls_rvalid), 32'h0);

    // load back 0x07
    ls_valid = 1'b1; ls_we = 1'b0; ls_addr = 8'h07; #1;
    check_val("ld_ls_ready", 32'(ls_ready), 32'h1);
    tick(); ls_valid = 1'b0; #1;
    check_val("ld_we", 32'(mem_we), 32'h0);
    tick();
    check_val("ld_rvalid", 32'(ls_rvalid), 32'h1);
    check_val("ld_rdata", 32'(ls_rdata), 32'hFFFF);
    tick();

    // preload 0x10 = 0xA5A5 through a store, then fetch it
    ls_valid = 1'b1; ls_we = 1'b1; ls_addr = 8'h10; ls_wdata = 16'hA5A5;
    tick(); ls_valid = 1'b0; ls_we = 1'b0;
    tick(); tick();
    if_valid = 1'b1; if_addr = 8'h10; #1;
    check_val("fe_if_ready", 32'(if_ready), 32'h1);
    tick(); if_valid = 1'b0; #1;
    check_val("fe_we", 32'(mem_we), 32'h0);
    check_val("fe_rvalid_n1", 32'(if_rvalid), 32'h0);
    tick();
    check_val("fe_rvalid", 32'(if_rvalid), 32'h1);
    check_val("fe_rdata", 32'(if_rdata), 32'hA5A5);
    check_val("fe_ls_rvalid", 32'(ls_rvalid), 32'h0);
    check_val("fe_we_n2", 32'(mem_we), 32'h0);
    tick();
    check_val("fe_rvalid_off", 32'(if_rvalid), 32'h0);

    // simultaneous requests: load/store first, fetch two cycles later
    ls_valid = 1'b1; ls_we = 1'b0; ls_addr = 8'h01;
    if_valid = 1'b1; if_addr = 8'h02; #1;
    check_val("sim_ls_ready", 32'(ls_ready), 32'h1);
    check_val("sim_if_ready0", 32'(if_ready), 32'h0);
    tick(); ls_valid = 1'b0; #1;
    check_val("sim_addr_ls", 32'(mem_addr), 32'h01);
    tick();
    check_val("sim_ls_rvalid", 32'(ls_rvalid), 32'h1);
    check_val("sim_if_rvalid0", 32'(if_rvalid), 32'h0);
    check_val("sim_if_ready", 32'(if_ready), 32'h1);
    tick(); if_valid = 1'b0; #1;
    check_val("sim_addr_if", 32'(mem_addr), 32'h02);
    tick();
    check_val("sim_if_rvalid", 32'(if_rvalid), 32'h1);
    check_val("sim_ls_rvalid0", 32'(ls_rvalid), 32'h0);
    tick();

    // continuous contention: 4 load/store grants then 1 fetch, repeated
    ls_valid = 1'b1; ls_we = 1'b0; ls_addr = 8'h20;
    if_valid = 1'b1; if_addr = 8'h30;
    gvec = 10'h0; gcount = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ls_ready && if_ready) check_val("both_ready", 32'h1, 32'h0);
      if ((ls_ready || if_ready) && gcount < 10) begin
        gvec[gcount] = ls_ready;
        gcount++;
      end
      tick();
    end
    check_val("starve_count", 32'(gcount), 32'd10);
    check_val("starve_order", 32'(gvec), 32'h1EF);
    ls_valid = 1'b0; if_valid = 1'b0;
    tick(); tick();

    // reset during a store access
    ls_valid = 1'b1; ls_we = 1'b1; ls_addr = 8'h40; ls_wdata = 16'h1234;
    tick(); ls_valid = 1'b0; ls_we = 1'b0; #1;
    check_val("rs_we_before", 32'(mem_we), 32'h1);
    #1 rst_n = 1'b0; #1;
    check_val("rs_we_async", 32'(mem_we), 32'h0);
    check_val("rs_addr_async", 32'(mem_addr), 32'h0);
    check_val("rs_rvalid_async", 32'(ls_rvalid), 32'h0);
    tick(); rst_n = 1'b1;
    tick();
    check_val("rs_no_rvalid", 32'(ls_rvalid), 32'h0);
    if_valid = 1'b1; if_addr = 8'h05; #1;
    check_val("rs_idle_ready", 32'(if_ready), 32'h1);
    tick(); if_valid = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
